vector_reader: RTL and testbench

- Bulk loader that fetches number_of_nodes consecutive words from memory, starting at starting_address, into an on-chip vector.
- The vector feeds the Dijkstra core, e.g. initial distances or adjacency-row weights.
- Read-side counterpart of the result writer; shares the same memory master port style (address/data/enable, wait_request, ready strobe).
- One outstanding read at a time; asserts ready when the whole vector is loaded.

---
 rtl/vector_reader_pkg.sv | 22 ++
 rtl/vector_reader_mem_read_port.sv | 55 +++++
 rtl/vector_reader.sv | 148 ++++++++++++++
 tb/tb_vector_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_reader_pkg.sv
// Shared types and helpers for the vector reader and its memory read port.
// Holds the FSM state encoding, address stride and element-count clamp.
package vector_reader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } reader_state_t;

    // Consecutive words sit one bus width apart in the byte address space.
    function automatic int unsigned stride_bytes(input int unsigned mdata_width);
        return mdata_width / 8;
    endfunction

    function automatic int unsigned clamp_count(input int unsigned requested,
                                                input int unsigned max_nodes);
        return (requested < max_nodes) ? requested : max_nodes;
    endfunction

endpackage

// File: rtl/vector_reader_mem_read_port.sv
// Single-word read handshake: holds the request until accepted, then waits
// for the data strobe. Reusable by any reader with one outstanding access.
module vector_reader_mem_read_port #(
    parameter int MADDR_WIDTH = 32,
    parameter int MDATA_WIDTH = 32,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   abort,
    input  logic                   request,
    input  logic [MADDR_WIDTH-1:0] addr,
    output logic                   mem_read_enable,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic                   wait_request,
    input  logic                   mem_read_valid,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    output logic                   accepted,
    output logic                   done,
    output logic [VALUE_WIDTH-1:0] data
);

    logic pending_q;

    assign mem_read_enable = request;
    assign mem_addr        = request ? addr : '0;
    assign accepted        = request & ~wait_request;
    assign done            = pending_q & mem_read_valid;

    // A response with no accepted request behind it (e.g. after an abort) is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else if (abort) begin
            pending_q <= 1'b0;
        end else if (accepted) begin
            pending_q <= 1'b1;
        end else if (done) begin
            pending_q <= 1'b0;
        end
    end

    generate
        if (VALUE_WIDTH < MDATA_WIDTH) begin : g_truncate
            logic unused_upper;
            assign unused_upper = ^mem_read_data[MDATA_WIDTH-1:VALUE_WIDTH];
            assign data         = mem_read_data[VALUE_WIDTH-1:0];
        end else if (VALUE_WIDTH == MDATA_WIDTH) begin : g_direct
            assign data = mem_read_data;
        end else begin : g_extend
            assign data = {{(VALUE_WIDTH-MDATA_WIDTH){1'b0}}, mem_read_data};
        end
    endgenerate

endmodule

// File: rtl/vector_reader.sv
// Bulk loader: reads a run of consecutive memory words into an on-chip vector.
//   state     | meaning
//   IDLE      | waiting for enable; latches base address and clamped count
//   ISSUE     | read request on the bus until accepted
//   WAIT_DATA | waiting for the read data strobe of the current element
//   DONE      | whole vector loaded; ready held until enable drops
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module vector_reader
    import vector_reader_pkg::*;
#(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [MADDR_WIDTH-1:0] starting_address,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    output logic                   mem_read_enable,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic                   wait_request,
    input  logic                   mem_read_valid,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    output logic [VALUE_WIDTH-1:0] value_vector [MAX_NODES],
    output logic                   ready
);

    localparam int CNT_W = $clog2(MAX_NODES + 1);
    localparam int SEL_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam int unsigned STRIDE_BYTES = stride_bytes(MDATA_WIDTH);

    reader_state_t          state_q, state_d;
    logic [MADDR_WIDTH-1:0] base_q;
    logic [MADDR_WIDTH-1:0] read_addr;
    logic [CNT_W-1:0]       count_q, count_in;
    logic [CNT_W-1:0]       index_q, index_next;
    logic                   ready_q;
    logic                   port_request;
    logic                   accepted;
    logic                   word_done;
    logic [VALUE_WIDTH-1:0] word_data;

    assign count_in   = CNT_W'(clamp_count(32'(number_of_nodes), MAX_NODES));
    assign index_next = index_q + CNT_W'(1);
    assign read_addr  = base_q + MADDR_WIDTH'(index_q) * MADDR_WIDTH'(STRIDE_BYTES);
    assign ready      = ready_q;

    vector_reader_mem_read_port #(
        .MADDR_WIDTH (MADDR_WIDTH),
        .MDATA_WIDTH (MDATA_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_port (
        .clock           (clock),
        .reset           (reset),
        .abort           (~enable),
        .request         (port_request),
        .addr            (read_addr),
        .mem_read_enable (mem_read_enable),
        .mem_addr        (mem_addr),
        .wait_request    (wait_request),
        .mem_read_valid  (mem_read_valid),
        .mem_read_data   (mem_read_data),
        .accepted        (accepted),
        .done            (word_done),
        .data            (word_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = (count_in == '0) ? DONE : ISSUE;
                ISSUE:     if (accepted) state_d = WAIT_DATA;
                WAIT_DATA: if (word_done) state_d = (index_next == count_q) ? DONE : ISSUE;
                DONE:      state_d = DONE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        port_request = 1'b0;
        if (state_q == ISSUE) begin
            port_request = 1'b1;
        end
    end

    // Entries are only ever written on their own load cycle, so a restart keeps older data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            count_q <= '0;
            index_q <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < MAX_NODES; i++) begin
                value_vector[i] <= '0;
            end
        end else if (!enable) begin
            index_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    base_q  <= starting_address;
                    count_q <= count_in;
                    index_q <= '0;
                end
                WAIT_DATA: begin
                    if (word_done) begin
                        value_vector[index_q[SEL_W-1:0]] <= word_data;
                        index_q <= index_next;
                    end
                end
                DONE:    ready_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_reader.sv
// Scoreboard bench for vector_reader: expected reads and completions are queued
// at stimulus time and checked by an independent monitor against the bus.
module tb_vector_reader;

    localparam int MAX_NODES   = 8;
    localparam int INDEX_WIDTH = 8;
    localparam int VALUE_WIDTH = 16;
    localparam int MADDR_WIDTH = 16;
    localparam int MDATA_WIDTH = 32;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [MADDR_WIDTH-1:0] starting_address;
    logic [INDEX_WIDTH-1:0] number_of_nodes;
    logic                   mem_read_enable;
    logic [MADDR_WIDTH-1:0] mem_addr;
    logic                   wait_request = 1'b0;
    logic                   mem_read_valid = 1'b0;
    logic [MDATA_WIDTH-1:0] mem_read_data = '0;
    logic [VALUE_WIDTH-1:0] value_vector [MAX_NODES];
    logic                   ready;

    vector_reader #(
        .MAX_NODES   (MAX_NODES),
        .INDEX_WIDTH (INDEX_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH),
        .MADDR_WIDTH (MADDR_WIDTH),
        .MDATA_WIDTH (MDATA_WIDTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .starting_address (starting_address),
        .number_of_nodes  (number_of_nodes),
        .mem_read_enable  (mem_read_enable),
        .mem_addr         (mem_addr),
        .wait_request     (wait_request),
        .mem_read_valid   (mem_read_valid),
        .mem_read_data    (mem_read_data),
        .value_vector     (value_vector),
        .ready            (ready)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model knobs, written by stimulus just after a rising edge.
    int req_count   = 0;
    int stall_req   = -1;
    int stall_left  = 0;
    int delay_req   = -1;
    int delay_extra = 0;
    int bias        = 0;
    int cd          = 0;
    logic [MADDR_WIDTH-1:0] resp_addr = '0;

    // Scoreboard queues.
    logic [MADDR_WIDTH-1:0] exp_addr [$];
    int                     exp_run  [$];
    int                     exp_cyc  [$];
    logic [127:0]           exp_vec  [$];

    function automatic logic [15:0] mem_value(input logic [MADDR_WIDTH-1:0] a);
        return 16'(bias + 5 + 2 * ((int'(a) - 32'h1000) >>> 2));
    endfunction

    function automatic logic [127:0] vec8(input int v0, input int v1, input int v2, input int v3,
                                          input int v4, input int v5, input int v6, input int v7);
        return {16'(v7), 16'(v6), 16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    function automatic logic [127:0] flat_vector();
        logic [127:0] v;
        for (int i = 0; i < MAX_NODES; i++) v[i*16 +: 16] = value_vector[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: wait_request per stall knobs, data one cycle after acceptance (plus optional delay).
    always @(negedge clock) begin
        mem_read_valid = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_read_valid = 1'b1;
                mem_read_data  = {16'hABCD, mem_value(resp_addr)};
            end
        end
        wait_request = 1'b0;
        if (mem_read_enable && req_count == stall_req && stall_left > 0) begin
            wait_request = 1'b1;
            stall_left--;
        end
        if (mem_read_enable && !wait_request) begin
            resp_addr = mem_addr;
            cd = 1 + ((req_count == delay_req) ? delay_extra : 0);
            req_count++;
        end
    end

    // Monitor: compares each accepted read and each ready rise against the queues.
    int   run_len    = 0;
    logic ready_prev = 1'b0;
    always @(negedge clock) begin
        #1;
        if (!mem_read_enable) begin
            run_len = 0;
        end else begin
            run_len++;
            if (!wait_request) begin
                if (exp_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", mem_addr);
                end else begin
                    check("read_addr", 128'(mem_addr), 128'(exp_addr.pop_front()));
                    check("request_hold_cycles", 128'(run_len), 128'(exp_run.pop_front()));
                end
                run_len = 0;
            end
        end
        if (ready && !ready_prev) begin
            if (exp_cyc.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                check("ready_cycle", 128'(cyc), 128'(exp_cyc.pop_front()));
                check("vector_contents", flat_vector(), exp_vec.pop_front());
            end
        end
        ready_prev = ready;
    end

    task automatic start_load(input logic [MADDR_WIDTH-1:0] addr, input int n, input int n_reads,
                              input int s_idx, input int s_cycles,
                              input logic [127:0] expv, input bit expect_ready);
        @(posedge clock);
        #1;
        req_count  = 0;
        stall_req  = s_idx;
        stall_left = s_cycles;
        for (int k = 0; k < n_reads; k++) begin
            exp_addr.push_back(addr + MADDR_WIDTH'(4 * k));
            exp_run.push_back((k == s_idx) ? 1 + s_cycles : 1);
        end
        if (expect_ready) begin
            exp_cyc.push_back(cyc + 2 * n_reads + 2 + s_cycles);
            exp_vec.push_back(expv);
        end
        starting_address = addr;
        number_of_nodes  = INDEX_WIDTH'(n);
        enable           = 1'b1;
    endtask

    task automatic wait_ready(input int max_cycles);
        int i = 0;
        while (!ready && i < max_cycles) begin
            @(negedge clock);
            i++;
        end
        #2;
        check("ready_reached", 128'(ready), 128'(1));
    endtask

    task automatic stop_load();
        @(posedge clock);
        #1;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("ready_cleared", 128'(ready), 128'(0));
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        starting_address = '0;
        number_of_nodes  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_mem_read_enable", 128'(mem_read_enable), 128'(0));
        check("reset_mem_addr", 128'(mem_addr), 128'(0));
        check("reset_ready", 128'(ready), 128'(0));
        check("reset_vector", flat_vector(), 128'(0));
        reset = 1'b0;

        // Basic four-element load, zero-wait memory.
        start_load(16'h1000, 4, 4, -1, 0, vec8(5, 7, 9, 11, 0, 0, 0, 0), 1'b1);
        wait_ready(40);
        stop_load();

        // Second request stalled three cycles.
        start_load(16'h1000, 4, 4, 1, 3, vec8(5, 7, 9, 11, 0, 0, 0, 0), 1'b1);
        wait_ready(40);
        stop_load();

        // Empty load: no memory traffic.
        start_load(16'h1000, 0, 0, -1, 0, vec8(5, 7, 9, 11, 0, 0, 0, 0), 1'b1);
        wait_ready(10);
        check("empty_load_reads", 128'(req_count), 128'(0));
        stop_load();

        // Count above MAX_NODES is clamped to eight reads.
        start_load(16'h1000, 12, 8, -1, 0, vec8(5, 7, 9, 11, 13, 15, 17, 19), 1'b1);
        wait_ready(60);
        check("clamped_reads", 128'(req_count), 128'(8));
        stop_load();

        // Abort while waiting on element 2; its late response must not land.
        bias        = 100;
        delay_req   = 2;
        delay_extra = 3;
        start_load(16'h1000, 4, 3, -1, 0, '0, 1'b0);
        for (int i = 0; i < 30 && req_count < 3; i++) begin
            @(posedge clock);
            #1;
        end
        check("abort_reads_before_drop", 128'(req_count), 128'(3));
        enable = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        delay_req = -1;
        check("abort_ready", 128'(ready), 128'(0));
        check("abort_mem_read_enable", 128'(mem_read_enable), 128'(0));
        check("abort_vector", flat_vector(), vec8(105, 107, 9, 11, 13, 15, 17, 19));

        // Restart after abort reloads from the base address.
        bias = 200;
        start_load(16'h1000, 4, 4, -1, 0, vec8(205, 207, 209, 211, 13, 15, 17, 19), 1'b1);
        wait_ready(40);
        stop_load();

        // Asynchronous reset while a request is being held off.
        start_load(16'h1000, 4, 0, 0, 20, '0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("issue_active", 128'(mem_read_enable), 128'(1));
        check("issue_addr", 128'(mem_addr), 128'(16'h1000));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mem_read_enable", 128'(mem_read_enable), 128'(0));
        check("async_reset_ready", 128'(ready), 128'(0));
        check("async_reset_vector", flat_vector(), 128'(0));
        stall_left = 0;
        stall_req  = -1;
        enable     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        check("leftover_expected_reads", 128'(exp_addr.size()), 128'(0));
        check("leftover_expected_ready", 128'(exp_cyc.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
